// File: rtl/led_pkg.sv
// Shared LED matrix types and constants.
// Used by the scan driver and the game block.
package led_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef logic [0:COLS-1] line_t;

  localparam line_t LED_OFF_LINE = 8'hFF;

  typedef enum logic {
    S_BLANK,
    S_DRIVE
  } scan_state_t;
endpackage

// File: rtl/led_frame_buffer.sv
// Double buffer for the LED frame: pending capture,
// active scan copy, swap only on a frame boundary.
module led_frame_buffer
  import led_pkg::*;
(
  input  logic             clk_1000,
  input  logic             restart,
  input  line_t [ROWS-1:0] frame_in,
  input  logic             frame_valid,
  input  logic             boundary,
  output line_t [ROWS-1:0] active_nxt,
  output logic             swap
);

  line_t [ROWS-1:0] active;
  line_t [ROWS-1:0] pending;
  logic             pend_flag;

  // A frame arriving on the boundary edge bypasses pending.
  always_comb begin
    active_nxt = active;
    swap       = 1'b0;
    if (boundary) begin
      if (frame_valid) begin
        active_nxt = frame_in;
        swap       = 1'b1;
      end else if (pend_flag) begin
        active_nxt = pending;
        swap       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1000) begin
    if (restart) begin
      active    <= {ROWS{LED_OFF_LINE}};
      pending   <= {ROWS{LED_OFF_LINE}};
      pend_flag <= 1'b0;
    end else begin
      active <= active_nxt;
      if (frame_valid) begin
        pending <= frame_in;
      end
      pend_flag <= swap ? 1'b0
                        : (pend_flag | frame_valid);
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed 8x8 LED scan driver with
// per-row dwell and anti-ghost blanking.
module led_matrix_scan
  import led_pkg::*;
#(
  parameter int DWELL = 1,
  parameter int BLANK = 1
) (
  input  logic             clk_1000,
  input  logic             restart,
  input  line_t [ROWS-1:0] frame_in,
  input  logic             frame_valid,
  output logic [ROWS-1:0]  row_sel,
  output line_t            col_n,
  output logic             frame_swap,
  output logic             frame_start
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DWELL_M1 = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_M1 =
    CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam scan_state_t FIRST =
    (BLANK > 0) ? S_BLANK : S_DRIVE;
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  scan_state_t      state;
  logic [2:0]       row_idx;
  logic [CW-1:0]    phase;
  logic             at_end;
  logic             swap;
  line_t [ROWS-1:0] active_nxt;

  led_frame_buffer u_buf (
    .clk_1000    (clk_1000),
    .restart     (restart),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .boundary    (at_end),
    .active_nxt  (active_nxt),
    .swap        (swap)
  );

  // state/row_idx/phase name the cycle the next edge presents;
  // at_end marks that the cycle on the pins is row 7's last drive.
  always_ff @(posedge clk_1000) begin
    if (restart) begin
      state       <= FIRST;
      row_idx     <= '0;
      phase       <= '0;
      at_end      <= 1'b0;
      row_sel     <= '0;
      col_n       <= LED_OFF_LINE;
      frame_swap  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_swap  <= swap;
      frame_start <= (state == FIRST) &&
                     (row_idx == '0) &&
                     (phase == '0);
      at_end      <= 1'b0;
      row_sel     <= '0;
      col_n       <= LED_OFF_LINE;
      unique case (state)
        S_BLANK: begin
          if (phase == BLANK_M1) begin
            state <= S_DRIVE;
            phase <= '0;
          end else begin
            phase <= phase + CW'(1);
          end
        end
        S_DRIVE: begin
          row_sel <= ROWS'(1) << row_idx;
          col_n   <= active_nxt[row_idx];
          if (phase == DWELL_M1) begin
            at_end  <= (row_idx == LAST_ROW);
            row_idx <= row_idx + 3'd1;
            phase   <= '0;
            state   <= FIRST;
          end else begin
            phase <= phase + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan: default timing
// plus a DWELL=3 / BLANK=0 instance.
module tb_led_matrix_scan;
  import led_pkg::*;

  typedef line_t [ROWS-1:0] frame_t;

  typedef struct {
    logic [7:0] rs;
    line_t      col;
    logic       sw;
    logic       st;
    int         id;
  } exp_t;

  localparam frame_t DIAG = {
    8'hFE, 8'hFD, 8'hFB, 8'hF7,
    8'hEF, 8'hDF, 8'hBF, 8'h7F
  };

  logic clk_1000 = 1'b0;
  always #5 clk_1000 = ~clk_1000;

  logic       restart;
  logic       frame_valid;
  frame_t     frame_in;
  logic [7:0] row_sel;
  line_t      col_n;
  logic       frame_swap;
  logic       frame_start;

  logic       restart3;
  logic       frame_valid3;
  logic [7:0] row_sel3;
  line_t      col_n3;
  logic       frame_swap3;
  logic       frame_start3;

  exp_t q[$];
  exp_t q3[$];
  exp_t me;
  exp_t me3;
  int   n_chk  = 0;
  int   n_fail = 0;

  led_matrix_scan dut (
    .clk_1000    (clk_1000),
    .restart     (restart),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .row_sel     (row_sel),
    .col_n       (col_n),
    .frame_swap  (frame_swap),
    .frame_start (frame_start)
  );

  led_matrix_scan #(
    .DWELL (3),
    .BLANK (0)
  ) dut3 (
    .clk_1000    (clk_1000),
    .restart     (restart3),
    .frame_in    (frame_in),
    .frame_valid (frame_valid3),
    .row_sel     (row_sel3),
    .col_n       (col_n3),
    .frame_swap  (frame_swap3),
    .frame_start (frame_start3)
  );

  function automatic frame_t fill(input line_t v);
    frame_t f;
    for (int r = 0; r < ROWS; r++) f[r] = v;
    return f;
  endfunction

  function automatic exp_t rst_exp(input int id);
    exp_t e;
    e = '{8'h00, 8'hFF, 1'b0, 1'b0, id};
    return e;
  endfunction

  task automatic chk(
    input string      nm,
    input logic [7:0] rs,
    input line_t      col,
    input logic       sw,
    input logic       st,
    input exp_t       e
  );
    n_chk++;
    if (rs !== e.rs || col !== e.col ||
        sw !== e.sw || st !== e.st) begin
      n_fail++;
      $display(
        "FAIL %s id=%0d: got row_sel=%h col_n=%h swap=%b start=%b, want %h %h %b %b",
        nm, e.id, rs, col, sw, st,
        e.rs, e.col, e.sw, e.st);
    end
  endtask

  // Monitor: one expected entry per clock edge per instance.
  always @(posedge clk_1000) begin
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("scan", row_sel, col_n,
          frame_swap, frame_start, me);
    end
    if (q3.size() > 0) begin
      me3 = q3.pop_front();
      chk("scan3", row_sel3, col_n3,
          frame_swap3, frame_start3, me3);
    end
  end

  task automatic step(
    input logic   rst,
    input logic   fv,
    input frame_t f,
    input exp_t   e
  );
    @(negedge clk_1000);
    restart     = rst;
    frame_valid = fv;
    frame_in    = f;
    q.push_back(e);
  endtask

  task automatic step3(input logic rst, input exp_t e);
    @(negedge clk_1000);
    restart3 = rst;
    q3.push_back(e);
  endtask

  // One 16-cycle frame at default timing; step j drives the
  // inputs sampled on the edge that presents cycle j.
  task automatic run_frame(
    input int          id,
    input frame_t      shown,
    input logic        swp,
    input logic [15:0] m1,
    input frame_t      f1,
    input logic [15:0] m2,
    input frame_t      f2,
    input int          rst_at
  );
    exp_t   e;
    frame_t f;
    logic   fv;
    for (int j = 0; j < 16; j++) begin
      fv = m1[j] | m2[j];
      f  = m2[j] ? f2 : f1;
      if (j >= rst_at) begin
        step(1'b1, 1'b0, f, rst_exp(id * 100 + j));
      end else begin
        e.id  = id * 100 + j;
        e.st  = (j == 0);
        e.sw  = swp && (j == 0);
        e.rs  = j[0] ? (8'h01 << (j / 2)) : 8'h00;
        e.col = j[0] ? shown[j / 2] : 8'hFF;
        step(1'b0, fv, f, e);
      end
    end
  endtask

  task automatic run3();
    exp_t e;
    for (int j = 0; j < 2; j++) step3(1'b1, rst_exp(900 + j));
    for (int j = 0; j < 48; j++) begin
      e.id  = 1000 + j;
      e.rs  = 8'h01 << ((j % 24) / 3);
      e.col = 8'hFF;
      e.sw  = 1'b0;
      e.st  = ((j % 24) == 0);
      step3(1'b0, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    restart      = 1'b1;
    restart3     = 1'b1;
    frame_valid  = 1'b0;
    frame_valid3 = 1'b0;
    frame_in     = fill(8'hFF);
    fork
      begin
        for (int i = 0; i < 2; i++)
          step(1'b1, 1'b0, fill(8'hFF), rst_exp(i));
        // diagonal captured mid-frame, shown next frame
        run_frame(1, fill(8'hFF), 1'b0,
                  16'h0080, DIAG,
                  16'h0000, fill(8'hFF), 16);
        // two captures in one frame: latest wins
        run_frame(2, DIAG, 1'b1,
                  16'h0008, fill(8'h00),
                  16'h0200, fill(8'hAA), 16);
        run_frame(3, fill(8'hAA), 1'b1,
                  16'h0000, fill(8'hFF),
                  16'h0000, fill(8'hFF), 16);
        run_frame(4, fill(8'hAA), 1'b0,
                  16'h0000, fill(8'hFF),
                  16'h0000, fill(8'hFF), 16);
        // capture exactly on the boundary edge
        run_frame(5, fill(8'h0F), 1'b1,
                  16'h0001, fill(8'h0F),
                  16'h0000, fill(8'hFF), 16);
        // restart during row 4 drive
        run_frame(6, fill(8'h0F), 1'b0,
                  16'h0000, fill(8'hFF),
                  16'h0000, fill(8'hFF), 10);
        step(1'b1, 1'b0, fill(8'hFF), rst_exp(700));
        run_frame(8, fill(8'hFF), 1'b0,
                  16'h0000, fill(8'hFF),
                  16'h0000, fill(8'hFF), 16);
        run_frame(9, fill(8'hFF), 1'b0,
                  16'h0000, fill(8'hFF),
                  16'h0000, fill(8'hFF), 16);
      end
      run3();
    join
    repeat (3) @(posedge clk_1000);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
- Row-multiplexed scan driver for the 8x8 LED matrix.
- Consumes the 8-line active-low frame produced by the game block (0 = lit, 1 = off).
- Double-buffers each frame so a scan never shows a half-updated picture.
- Drives one row at a time, with a programmable dwell and anti-ghost blanking between rows.

Parameters:
- ROWS, 8, number of matrix lines scanned; fixed at 8 for this matrix.
- COLS, 8, pixels per line; fixed at 8.
- DWELL, 1, clk_1000 cycles each row is driven; must be >= 1.
- BLANK, 1, clk_1000 cycles of all-off before each row; 0 disables blanking.

Ports:
- clk_1000, input, 1, scan clock (1 kHz). This is the only clock.
- restart, input, 1, reset: synchronous, active-high.
- frame_in, input, 8 x [0:7], frame lines; frame_in[r] bit c is pixel (r,c); active-low.
- frame_valid, input, 1, frame_in is presented for capture this cycle.
- row_sel, output, [7:0], one-hot active-high row enable; bit r drives row r.
- col_n, output, [0:7], active-low column drive for the selected row.
- frame_swap, output, 1, one-cycle pulse: a new frame became active.
- frame_start, output, 1, one-cycle pulse on the first cycle of row 0.

Behaviour:
- Registers:
  - active[8]: the line buffer currently being scanned.
  - pending[8] plus pend_flag: the next frame waiting for a frame boundary.
  - row_idx (3 bits), phase counter, state in {S_BLANK, S_DRIVE}.
- Reset, while restart = 1 on any edge, including mid-row:
  - active and pending all 8'hFF; pend_flag = 0.
  - row_idx = 0; phase counter = 0.
  - row_sel = 0, col_n = 8'hFF, frame_swap = 0, frame_start = 0.
  - state = S_BLANK if BLANK > 0, else S_DRIVE.
- All outputs are registered. The first cycle after restart falls is row 0 (BLANK phase, or DRIVE phase if BLANK = 0), and frame_start = 1 in that cycle.
- S_BLANK:
  - Outputs: row_sel = 0, col_n = 8'hFF.
  - Held for BLANK cycles, then moves to S_DRIVE with the same row_idx.
- S_DRIVE:
  - Outputs: row_sel = 1 << row_idx, col_n = active[row_idx].
  - Held for DWELL cycles.
  - Then row_idx = row_idx + 1, wrapping 7 -> 0, and the state returns to S_BLANK (or stays in S_DRIVE if BLANK = 0).
- Timing:
  - Row period = BLANK + DWELL cycles; frame period = 8 * (BLANK + DWELL).
  - Defaults: 16 cycles, i.e. 62.5 Hz refresh.
- Capture:
  - On any edge with frame_valid = 1: pending <= frame_in and pend_flag <= 1.
  - Latest frame wins; there is no backpressure and no overflow error.
- Frame boundary is the edge that ends the last DRIVE cycle of row 7. On that edge:
  - If frame_valid = 1: active <= frame_in directly (bypass), pend_flag <= 0, frame_swap = 1 next cycle.
  - Else if pend_flag = 1: active <= pending, pend_flag <= 0, frame_swap = 1 next cycle.
  - Else: active unchanged and frame_swap = 0.
- active never changes except at a boundary or on restart. A row is never shown with mixed frames.
- row_sel is never multi-hot. With BLANK = 0, row_sel is never all-zero after reset.
- Counter width = $clog2(max(DWELL, BLANK) + 1). There are no other arithmetic paths.

Decomposition:
- Shared package led_pkg holds:
  - ROWS and COLS constants.
  - LED_OFF_LINE = 8'hFF.
  - typedef line_t = logic [0:7].
  - scan_state_t enum {S_BLANK, S_DRIVE}.
- The game block imports the same LED_OFF_LINE and line_t.
- One sub-module, led_frame_buffer, holds pending, active and pend_flag, with capture, bypass and swap-on-boundary logic. The scan FSM, counters and output registers stay in led_matrix_scan.

Test Plan:
- Reset, defaults: restart high 2 cycles, then low.
  - While high: row_sel = 0, col_n = FF.
  - Cycle 0: frame_start = 1, row_sel = 0. Cycle 1: row_sel = 8'h01, col_n = FF.
  - Cycle 3: row_sel = 8'h02. Cycle 15: row_sel = 8'h80. Cycle 16: frame_start = 1 again.
- Diagonal frame (frame_in[r] = ~(8'h80 >> r)), frame_valid pulsed during row 3 of frame 0:
  - Remaining rows of frame 0 still show FF.
  - frame_swap = 1 on frame 1 cycle 0.
  - Frame 1 row r drive shows the diagonal pattern, e.g. row 2 gives col_n = 8'hDF.
- Two frame_valid pulses in one frame (all-8'h00, then all-8'hAA): frame 1 shows only 8'hAA on every row; one frame_swap pulse.
- frame_valid with 8'h0F lines on exactly the boundary edge (row 7 drive, cycle 15): frame_swap next cycle; every frame 1 row shows 8'h0F.
- restart asserted during row 4 drive after a frame has been loaded:
  - Next cycle: row_sel = 0, col_n = FF.
  - After release, a full frame shows FF; frame_swap stays 0.
- DWELL = 3, BLANK = 0: each one-hot row_sel is held 3 cycles; frame_start every 24 cycles; row_sel never 0 after reset.
